// File: rtl/calc_display_driver.sv
// Shift-add-3 BCD converter for the calculator result plus a 4-digit multiplexed 7-segment scanner.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros on the hundreds/tens digits.
module calc_display_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  calc_out,
  input  logic        op_mul,
  output logic        busy,
  output logic        bcd_valid,
  output logic [11:0] bcd_out,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  logic [8:0]    in_q;
  logic          in_q_valid;
  logic [8:0]    snap;
  logic          start_pending;
  logic [19:0]   sh;
  logic [2:0]    iter;
  logic          ovf_snap;
  logic          ovf_q;
  logic [7:0]    value;
  logic          ovf_in;
  logic          change;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [6:0]    digit_seg;

  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int k = 0; k < 3; k++) begin
      if (t[8 + 4*k +: 4] >= 4'd5) t[8 + 4*k +: 4] = t[8 + 4*k +: 4] + 4'd3;
      else                         t[8 + 4*k +: 4] = t[8 + 4*k +: 4];
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  // Add/sub results carry the overflow flag in bit 7 and only 5 magnitude bits.
  always_comb begin
    if (in_q[8]) value = in_q[7:0];
    else         value = {3'b000, in_q[4:0]};
  end

  assign ovf_in = ~in_q[8] & in_q[7];
  assign change = (in_q != snap);

  // Input stage: one register of the raw {op_mul, calc_out} pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q       <= 9'd0;
      in_q_valid <= 1'b0;
    end else begin
      in_q       <= {op_mul, calc_out};
      in_q_valid <= 1'b1;
    end
  end

  // Conversion FSM; in_q_valid keeps the post-reset forced start from using a stale in_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      snap          <= 9'd0;
      start_pending <= 1'b1;
      sh            <= 20'd0;
      iter          <= 3'd0;
      ovf_snap      <= 1'b0;
      ovf_q         <= 1'b0;
      busy          <= 1'b0;
      bcd_valid     <= 1'b0;
      bcd_out       <= 12'd0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_q_valid && (start_pending || change)) begin
            snap          <= in_q;
            ovf_snap      <= ovf_in;
            sh            <= {12'd0, value};
            iter          <= 3'd0;
            start_pending <= 1'b0;
            busy          <= 1'b1;
            state         <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          sh   <= dabble_step(sh);
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= DONE;
          else              state <= SHIFT;
        end
        DONE: begin
          bcd_out   <= sh[19:8];
          ovf_q     <= ovf_snap;
          bcd_valid <= 1'b1;
          busy      <= change;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Glyph for the digit currently selected by the scan index.
  always_comb begin
    digit_seg = SEG_BLANK;
    case (idx)
      2'd0: digit_seg = glyph(bcd_out[3:0]);
      2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd_out[11:4] == 8'd0) digit_seg = SEG_BLANK;
        else                       digit_seg = glyph(bcd_out[7:4]);
`else
        digit_seg = glyph(bcd_out[7:4]);
`endif
      end
      2'd2: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd_out[11:8] == 4'd0) digit_seg = SEG_BLANK;
        else                       digit_seg = glyph(bcd_out[11:8]);
`else
        digit_seg = glyph(bcd_out[11:8]);
`endif
      end
      2'd3: begin
        if (ovf_q) digit_seg = SEG_E;
        else       digit_seg = SEG_BLANK;
      end
      default: digit_seg = SEG_BLANK;
    endcase
  end

  // Display scanner; an and seg are registered together so they switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= 2'd0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      if (presc == PRESC_MAX) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + {{(PW-1){1'b0}}, 1'b1};
        idx   <= idx;
      end
      an  <= ~(4'b0001 << idx);
      seg <= digit_seg;
      dp  <= 1'b1;
    end
  end

endmodule
